// File: rtl/psx_host_poller.sv
// psx_host_poller
//   Console-side master for the PSX pad link. On a start request it lowers att,
//   clocks out the 5-byte poll 01,42,00,00,00 (LSB first on cmd), shifts in the
//   pad reply FF,ID,5A,DATA1,DATA2 from data, and waits for the pad's ack pulse
//   after each of bytes 0-3. A reply with ID 41 and 5A in byte 2 updates
//   buttons_n and pulses done; an ack timeout or bad header pulses error.
//   After every poll att stays high for ATT_HOLD cycles before a new start is
//   accepted.
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             1-cycle poll request (ignored while busy)
//   data, ack         pad -> host serial bit, pad ack (active low)
//   att, psx_clk, cmd link outputs (all idle high)
//   busy              poll in progress or hold interval running
//   buttons_n         {DATA2,DATA1} of last good poll, active low
//   done, error       1-cycle result pulses
module psx_host_poller #(
  parameter int CLK_DIV     = 4,
  parameter int ATT_SETUP   = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int BYTE_GAP    = 4,
  parameter int ATT_HOLD    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        att,
  output logic        psx_clk,
  output logic        cmd,
  output logic        busy,
  output logic [15:0] buttons_n,
  output logic        done,
  output logic        error
);

  localparam int MAX_A = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
  localparam int MAX_B = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > ATT_HOLD) ? MAX_C : ATT_HOLD;
  localparam int CW    = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(ATT_SETUP - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(ATT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_ACK_WAIT, S_GAP, S_FINISH, S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    shift;
  logic [7:0]    id_byte;
  logic [7:0]    sig_byte;
  logic [7:0]    d1_byte;
  logic          ack_s1;
  logic          ack_s2;
  logic          ack_low_seen;
  logic          aborted;

  // Outgoing poll bytes: 01, 42, then 00 for the rest.
  function automatic logic cmd_bit(input logic [2:0] idx, input logic [2:0] b);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'h01;
      3'd1:    v = 8'h42;
      default: v = 8'h00;
    endcase
    return v[b];
  endfunction

  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      id_byte      <= '0;
      sig_byte     <= '0;
      d1_byte      <= '0;
      ack_s1       <= 1'b1;
      ack_s2       <= 1'b1;
      ack_low_seen <= 1'b0;
      aborted      <= 1'b0;
      att          <= 1'b1;
      psx_clk      <= 1'b1;
      cmd          <= 1'b1;
      busy         <= 1'b0;
      buttons_n    <= '1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      ack_s1 <= ack;
      ack_s2 <= ack_s1;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            att      <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            aborted  <= 1'b0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            psx_clk <= 1'b0;
            cmd     <= cmd_bit(byte_idx, bit_idx);
            state   <= S_BIT_LO;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_BIT_LO: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            psx_clk <= 1'b1;
            shift   <= {data, shift[7:1]};
            state   <= S_BIT_HI;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_BIT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              case (byte_idx)
                3'd1:    id_byte  <= shift;
                3'd2:    sig_byte <= shift;
                3'd3:    d1_byte  <= shift;
                default: ;
              endcase
              ack_low_seen <= 1'b0;
              state        <= (byte_idx == 3'd4) ? S_FINISH : S_ACK_WAIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              psx_clk <= 1'b0;
              cmd     <= cmd_bit(byte_idx, bit_idx + 3'd1);
              state   <= S_BIT_LO;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ACK_WAIT: begin
          // Need a synced low followed by a synced high before moving on.
          if (ack_low_seen && ack_s2) begin
            cnt   <= '0;
            state <= S_GAP;
          end else if (cnt == ACK_LAST) begin
            aborted <= 1'b1;
            state   <= S_FINISH;
          end else begin
            cnt <= cnt_inc;
            if (!ack_s2) ack_low_seen <= 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 3'd1;
            bit_idx  <= '0;
            psx_clk  <= 1'b0;
            cmd      <= cmd_bit(byte_idx + 3'd1, 3'd0);
            state    <= S_BIT_LO;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_FINISH: begin
          att     <= 1'b1;
          psx_clk <= 1'b1;
          cmd     <= 1'b1;
          cnt     <= '0;
          state   <= S_HOLD;
          // shift still holds byte 4 here.
          if (aborted) begin
            error <= 1'b1;
          end else if (id_byte == 8'h41 && sig_byte == 8'h5A) begin
            buttons_n <= {shift, d1_byte};
            done      <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psx_host_poller.sv
module tb_psx_host_poller;

  typedef struct packed {
    logic        is_done;
    logic [15:0] btn;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, data, ack, sel;
  logic        start1, start2;
  logic        att1, pclk1, cmd1, busy1, done1, err1;
  logic        att2, pclk2, cmd2, busy2, done2, err2;
  logic [15:0] btn1, btn2;
  logic        s_att, s_pclk, s_cmd, s_busy, s_done, s_error;
  logic [15:0] s_btn;

  assign start1  = start & ~sel;
  assign start2  = start & sel;
  assign s_att   = sel ? att2  : att1;
  assign s_pclk  = sel ? pclk2 : pclk1;
  assign s_cmd   = sel ? cmd2  : cmd1;
  assign s_busy  = sel ? busy2 : busy1;
  assign s_done  = sel ? done2 : done1;
  assign s_error = sel ? err2  : err1;
  assign s_btn   = sel ? btn2  : btn1;

  psx_host_poller #(.CLK_DIV(4), .ATT_SETUP(8), .ACK_TIMEOUT(64), .BYTE_GAP(4), .ATT_HOLD(16)) u_dut (
    .clk(clk), .reset(reset), .start(start1), .data(data), .ack(ack),
    .att(att1), .psx_clk(pclk1), .cmd(cmd1), .busy(busy1), .buttons_n(btn1),
    .done(done1), .error(err1)
  );

  psx_host_poller #(.CLK_DIV(2), .ATT_SETUP(2)) u_dut_fast (
    .clk(clk), .reset(reset), .start(start2), .data(data), .ack(ack),
    .att(att2), .psx_clk(pclk2), .cmd(cmd2), .busy(busy2), .buttons_n(btn2),
    .done(done2), .error(err2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int att_rises = 0;
  int res_cyc   = 0;
  int min_per   = 1000;
  int pad_bytec = 0;
  int pad_bitc  = 0;
  logic [7:0] pad_id = 8'h41, pad_d1 = 8'h7F, pad_d2 = 8'hFF;
  bit ack_en = 1'b1;

  logic [7:0] cmd_q[$];
  res_t       exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad model: shifts reply bits out on psx_clk fall, captures cmd on rise,
  // pulses ack low for 3 cycles a few cycles after bytes 0-3.
  initial begin
    logic       p_prev;
    logic [7:0] rx, txb, e;
    int         ackc;
    p_prev = 1'b1; rx = '0; ackc = 0;
    data = 1'b1; ack = 1'b1;
    forever begin
      @(negedge clk);
      if (s_att) begin
        pad_bitc = 0; pad_bytec = 0; ackc = 0; ack = 1'b1; data = 1'b1;
      end else begin
        if (p_prev && !s_pclk) begin
          case (pad_bytec)
            0:       txb = 8'hFF;
            1:       txb = pad_id;
            2:       txb = 8'h5A;
            3:       txb = pad_d1;
            default: txb = pad_d2;
          endcase
          data = txb[pad_bitc];
        end
        if (!p_prev && s_pclk) begin
          rx = {s_cmd, rx[7:1]};
          if (pad_bitc == 7) begin
            pad_bitc = 0;
            e = (cmd_q.size() > 0) ? cmd_q.pop_front() : 8'hxx;
            chk("cmd_byte", 32'(rx), 32'(e));
            if (pad_bytec < 4 && ack_en) ackc = 1;
            pad_bytec++;
          end else begin
            pad_bitc++;
          end
        end
        if (ackc != 0) begin
          ackc++;
          if (ackc == 8) ack = 1'b0;
          else if (ackc == 11) begin ack = 1'b1; ackc = 0; end
        end
      end
      p_prev = s_pclk;
    end
  end

  // Result monitor: pops one expectation per done/error pulse.
  initial begin
    logic prev_att, prev_pclk;
    int   last_fall;
    res_t e;
    prev_att = 1'b1; prev_pclk = 1'b1; last_fall = -1;
    forever begin
      @(negedge clk);
      if (s_done || s_error) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("result_kind_done", 32'(s_done), 32'(e.is_done));
        chk("buttons_n", 32'(s_btn), 32'(e.btn));
        chk("done_error_excl", 32'(s_done & s_error), 32'h0);
        res_cyc = cyc;
      end
      if (!prev_att && s_att) att_rises++;
      if (prev_pclk && !s_pclk) begin
        if (last_fall >= 0 && (cyc - last_fall) < min_per) min_per = cyc - last_fall;
        last_fall = cyc;
      end
      prev_att  = s_att;
      prev_pclk = s_pclk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (s_busy && n < budget) begin @(negedge clk); n++; end
    chk("busy_released", 32'(s_busy), 32'h0);
  endtask

  task automatic push_cmd(input int n);
    logic [7:0] c [5];
    c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < n; i++) cmd_q.push_back(c[i]);
  endtask

  task automatic push_res(input logic d, input logic [15:0] b);
    res_t r;
    r.is_done = d; r.btn = b;
    exp_q.push_back(r);
  endtask

  task automatic poll(input logic [7:0] id, input logic [7:0] d1, input logic [7:0] d2,
                      input bit ack_on, input int ncmd, input logic exp_done,
                      input logic [15:0] exp_btn, input int exp_per);
    int rises0;
    pad_id = id; pad_d1 = d1; pad_d2 = d2; ack_en = ack_on;
    push_cmd(ncmd);
    push_res(exp_done, exp_btn);
    min_per = 1000;
    rises0 = att_rises;
    pulse_start;
    chk("busy_on_start", 32'(s_busy), 32'h1);
    chk("att_low_on_start", 32'(s_att), 32'h0);
    wait_idle(3000);
    chk("att_single_rise", 32'(att_rises - rises0), 32'd1);
    chk("hold_len", 32'(cyc - res_cyc), 32'd16);
    chk("psx_clk_period", 32'(min_per), 32'(exp_per));
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_att", 32'(s_att), 32'h1);
    chk("rst_psx_clk", 32'(s_pclk), 32'h1);
    chk("rst_cmd", 32'(s_cmd), 32'h1);
    chk("rst_busy", 32'(s_busy), 32'h0);
    chk("rst_buttons", 32'(s_btn), 32'hFFFF);
    chk("rst_done", 32'(s_done), 32'h0);
    chk("rst_error", 32'(s_error), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Ack never arrives: timeout after byte 0.
    poll(8'h41, 8'h7F, 8'hFF, 1'b0, 1, 1'b0, 16'hFFFF, 8);
    // Normal poll.
    poll(8'h41, 8'h7F, 8'hFF, 1'b1, 5, 1'b1, 16'hFF7F, 8);
    // Bad ID: buttons must keep FF7F even though the pad sends 0000.
    poll(8'h73, 8'h00, 8'h00, 1'b1, 5, 1'b0, 16'hFF7F, 8);

    // Reset in the middle of byte 2.
    pad_id = 8'h41; pad_d1 = 8'h7F; pad_d2 = 8'hFF; ack_en = 1'b1;
    push_cmd(2);
    pulse_start;
    n = 0;
    while (!(pad_bytec == 2 && pad_bitc >= 3) && n < 3000) begin @(negedge clk); n++; end
    chk("reached_byte2", 32'(pad_bytec), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_att", 32'(s_att), 32'h1);
    chk("midrst_psx_clk", 32'(s_pclk), 32'h1);
    chk("midrst_busy", 32'(s_busy), 32'h0);
    chk("midrst_buttons", 32'(s_btn), 32'hFFFF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    poll(8'h41, 8'h7F, 8'hFF, 1'b1, 5, 1'b1, 16'hFF7F, 8);

    // Starts while busy and during hold are dropped; first idle cycle accepted.
    push_cmd(5);
    push_res(1'b1, 16'hFF7F);
    pulse_start;
    repeat (100) @(negedge clk);
    pulse_start;
    n = 0;
    while (!s_done && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", 32'(s_done), 32'h1);
    repeat (3) @(negedge clk);
    pulse_start;
    chk("busy_in_hold", 32'(s_busy), 32'h1);
    wait_idle(100);
    push_cmd(5);
    push_res(1'b1, 16'hFF7F);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_first_idle", 32'(s_busy), 32'h1);
    wait_idle(3000);

    // Faster link instance.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    poll(8'h41, 8'h7F, 8'hFF, 1'b1, 5, 1'b1, 16'hFF7F, 4);

    repeat (20) @(negedge clk);
    chk("results_pending", 32'(exp_q.size()), 32'd0);
    chk("cmd_pending", 32'(cmd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
